memctrl_burst: RTL and testbench
================================

Name: memctrl_burst

Overview:
- Responder end of the cache-to-main-memory burst interface.
- Accepts word-aligned burst read/write requests from one cache client (dcache or icache) and executes them as BURSTLEN single-word transactions on a generic RAM back-end port.
- Read data returns one registered beat at a time with mem_datavalid. Write data is consumed one word per mem_datavalid.
- Sits between the cache and the external memory/SDRAM adapter.

Parameters:
- BURSTLEN, 8: words per burst; driven on mem_burstlen; must be a power of 2 and at least 2.
- LOG2_BURST, 3: log2(BURSTLEN); used for counter width and wrap arithmetic.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- mem_addr  in  32  burst start byte address; bits [1:0] ignored
- mem_rdreq  in  1  burst read request, sampled in IDLE
- mem_wrreq  in  1  burst write request, sampled in IDLE
- mem_datain  in  32  write data from client
- mem_dataout  out  32  read data to client
- mem_datavalid  out  1  read beat valid / write word consumed
- mem_burstlen  out  16  constant BURSTLEN
- mem_busy  out  1  high while not IDLE
- ram_addr  out  32  word-aligned back-end address
- ram_rdreq  out  1  back-end read request
- ram_wrreq  out  1  back-end write request
- ram_wdata  out  32  back-end write data
- ram_ready  in  1  back-end accepts the request at this edge
- ram_rdata  in  32  back-end read data
- ram_rvalid  in  1  ram_rdata valid, in order

Behaviour:
- Reset (async, reset_n low): state IDLE; all counters 0; base 0. mem_dataout=0, mem_datavalid=0, mem_busy=0, ram_rdreq=0, ram_wrreq=0, ram_addr=0, ram_wdata=0. mem_burstlen is constant BURSTLEN at all times, including during reset.
- States: IDLE, RD, WR.
- IDLE transitions:
  - mem_rdreq=1 → latch base={mem_addr[31:2],2'b00}, clear issue and return counters, go to RD.
  - Otherwise mem_wrreq=1 → latch base, clear counter, go to WR.
  - Both requests high → read wins; the write is dropped and the client must reissue it.
- Requests in RD or WR are ignored. The client re-requests only after counting BURSTLEN beats.
- Address generation: ram_addr = base + 4*cnt, where cnt is the issue counter in RD and the write counter in WR. Width 32, wraps modulo 2^32.
- RD state:
  - ram_rdreq = (issued < BURSTLEN), combinational.
  - issued increments at each edge with ram_rdreq & ram_ready.
  - Each ram_rvalid (RD only) registers ram_rdata into mem_dataout and sets mem_datavalid=1 the next cycle (1-cycle latency). Otherwise mem_datavalid=0 and mem_dataout holds its value.
  - returned increments on ram_rvalid.
  - When returned reaches BURSTLEN → IDLE. The final mem_datavalid beat appears in the first IDLE cycle.
  - ram_rvalid seen in IDLE or WR is ignored.
- WR state:
  - ram_wrreq=1, ram_wdata=mem_datain (combinational pass-through).
  - mem_datavalid = ram_ready (combinational): the client's word is written at that edge, and the client presents the next word on the following cycle.
  - Counter increments per accepted word. The edge accepting word BURSTLEN-1 → IDLE.
- Counters are LOG2_BURST+1 bits wide, so they reach BURSTLEN without overflow.
- mem_busy = (state != IDLE).
- Reset mid-burst: immediate abort; outstanding back-end reads arriving after reset are ignored.

Optional Feature:
- Macro: MEMCTRL_WRAP_EN.
- Defined: critical-word-first wrap burst. The address is
  {base[31:LOG2_BURST+2], (base[LOG2_BURST+1:2]+cnt)[LOG2_BURST-1:0], 2'b00}, so the burst stays within the BURSTLEN-aligned block.
- Undefined: linear increment as specified under Behaviour.

Decomposition:
- Package memctrl_pkg:
  - state encoding constants (IDLE=2'b00, RD=2'b01, WR=2'b10)
  - default BURSTLEN/LOG2_BURST
  - bus width constant 32
- Sub-module memctrl_addrgen (combinational):
  - inputs base and cnt; output ram_addr
  - contains the MEMCTRL_WRAP_EN linear/wrap selection

Test Plan:
- Read, zero-wait: RAM model with ram_ready=1, 1-cycle rvalid, data=address. rdreq at 0x100 → 8 mem_datavalid beats with data 0x100,0x104,…,0x11C, then mem_busy=0.
- Wrap: rdreq at 0x118 with MEMCTRL_WRAP_EN → data 0x118,0x11C,0x100,…,0x114. Without the macro → 0x118…0x134.
- Write with backpressure: wrreq at 0x200, ram_ready pattern 1,0,0,1,1,0,1… → exactly 8 mem_datavalid pulses coinciding with ready. RAM holds words D0..D7 at 0x200..0x21C; no duplicated or skipped word.
- Collision/ignore: rdreq=wrreq=1 at 0x40 → read burst only, ram_wrreq never asserted. A rdreq pulsed mid-burst → no extra beats.
- Read latency 3 with ready toggling → 8 beats in order, correct data, no beat lost.
- Reset mid-read after 3 beats → all outputs 0 asynchronously, state IDLE. Late ram_rvalid → no mem_datavalid. Next rdreq at 0x300 completes a clean 8-beat burst.

Source files
------------

// File: rtl/memctrl_pkg.sv
// Shared constants for the memctrl burst responder.
// State encodings, default burst geometry and bus width.
package memctrl_pkg;

  localparam int BUS_W          = 32;
  localparam int DEF_BURSTLEN   = 8;
  localparam int DEF_LOG2_BURST = 3;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RD   = 2'b01;
  localparam logic [1:0] ST_WR   = 2'b10;

endpackage

// File: rtl/memctrl_addrgen.sv
// Back-end word address from burst base and beat counter.
// MEMCTRL_WRAP_EN selects critical-word-first wrap within the block.
module memctrl_addrgen
  import memctrl_pkg::*;
#(
  parameter int LOG2_BURST = DEF_LOG2_BURST
) (
  input  logic [BUS_W-1:0]    base,
  input  logic [LOG2_BURST:0] cnt,
  output logic [BUS_W-1:0]    ram_addr
);

`ifdef MEMCTRL_WRAP_EN
  logic [LOG2_BURST-1:0] off;
  logic                  unused_msb;

  // Offset wraps inside the BURSTLEN-aligned block.
  assign off        = base[LOG2_BURST+1:2] + cnt[LOG2_BURST-1:0];
  assign unused_msb = cnt[LOG2_BURST];
  assign ram_addr   = {base[BUS_W-1:LOG2_BURST+2], off, 2'b00};
`else
  assign ram_addr = base
                  + {{(BUS_W-LOG2_BURST-3){1'b0}}, cnt, 2'b00};
`endif

endmodule

// File: rtl/memctrl_burst.sv
// Burst responder: cache bursts to single-word RAM transactions.
// Optional macro MEMCTRL_WRAP_EN enables wrap-burst addressing.
module memctrl_burst
  import memctrl_pkg::*;
#(
  parameter int BURSTLEN   = DEF_BURSTLEN,
  parameter int LOG2_BURST = DEF_LOG2_BURST
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [BUS_W-1:0] mem_addr,
  input  logic             mem_rdreq,
  input  logic             mem_wrreq,
  input  logic [BUS_W-1:0] mem_datain,
  output logic [BUS_W-1:0] mem_dataout,
  output logic             mem_datavalid,
  output logic [15:0]      mem_burstlen,
  output logic             mem_busy,
  output logic [BUS_W-1:0] ram_addr,
  output logic             ram_rdreq,
  output logic             ram_wrreq,
  output logic [BUS_W-1:0] ram_wdata,
  input  logic             ram_ready,
  input  logic [BUS_W-1:0] ram_rdata,
  input  logic             ram_rvalid
);

  localparam int CNT_W = LOG2_BURST + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BURSTLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURSTLEN - 1);

  logic [1:0]       state;
  logic [BUS_W-1:0] base;
  logic [CNT_W-1:0] issued;
  logic [CNT_W-1:0] returned;
  logic             rd_valid;
  logic [1:0]       unused_lsb;

  assign unused_lsb = mem_addr[1:0];

  memctrl_addrgen #(
    .LOG2_BURST (LOG2_BURST)
  ) u_addrgen (
    .base     (base),
    .cnt      (issued),
    .ram_addr (ram_addr)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      base        <= '0;
      issued      <= '0;
      returned    <= '0;
      rd_valid    <= 1'b0;
      mem_dataout <= '0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Read wins a collision; the write is dropped.
          if (mem_rdreq) begin
            base     <= {mem_addr[BUS_W-1:2], 2'b00};
            issued   <= '0;
            returned <= '0;
            state    <= ST_RD;
          end else if (mem_wrreq) begin
            base   <= {mem_addr[BUS_W-1:2], 2'b00};
            issued <= '0;
            state  <= ST_WR;
          end
        end
        ST_RD: begin
          if (ram_rdreq && ram_ready)
            issued <= issued + 1'b1;
          if (ram_rvalid) begin
            mem_dataout <= ram_rdata;
            rd_valid    <= 1'b1;
            returned    <= returned + 1'b1;
            if (returned == CNT_LAST)
              state <= ST_IDLE;
          end
        end
        ST_WR: begin
          if (ram_ready) begin
            issued <= issued + 1'b1;
            if (issued == CNT_LAST)
              state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ram_rdreq     = (state == ST_RD) && (issued < CNT_FULL);
  assign ram_wrreq     = (state == ST_WR);
  assign ram_wdata     = ram_wrreq ? mem_datain : '0;
  assign mem_datavalid = ram_wrreq ? ram_ready : rd_valid;
  assign mem_busy      = (state != ST_IDLE);
  assign mem_burstlen  = 16'(BURSTLEN);

endmodule

// File: tb/tb_memctrl_burst.sv
// Directed bench for memctrl_burst with a latency-configurable RAM model.
// Expected data is the word address for reads and D000_0000+i for writes.
module tb_memctrl_burst;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] mem_addr;
  logic        mem_rdreq;
  logic        mem_wrreq;
  logic [31:0] mem_datain = '0;
  logic [31:0] mem_dataout;
  logic        mem_datavalid;
  logic [15:0] mem_burstlen;
  logic        mem_busy;
  logic [31:0] ram_addr;
  logic        ram_rdreq;
  logic        ram_wrreq;
  logic [31:0] ram_wdata;
  logic        ram_ready = 1'b0;
  logic [31:0] ram_rdata = '0;
  logic        ram_rvalid = 1'b0;

  memctrl_burst dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .mem_addr      (mem_addr),
    .mem_rdreq     (mem_rdreq),
    .mem_wrreq     (mem_wrreq),
    .mem_datain    (mem_datain),
    .mem_dataout   (mem_dataout),
    .mem_datavalid (mem_datavalid),
    .mem_burstlen  (mem_burstlen),
    .mem_busy      (mem_busy),
    .ram_addr      (ram_addr),
    .ram_rdreq     (ram_rdreq),
    .ram_wrreq     (ram_wrreq),
    .ram_wdata     (ram_wdata),
    .ram_ready     (ram_ready),
    .ram_rdata     (ram_rdata),
    .ram_rvalid    (ram_rvalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        pend[$];
  logic [31:0] rxq[$];
  logic [31:0] mem[logic [31:0]];
  int          cyc = 0;
  int          lat = 1;
  int          rdy_mode = 0;
  int          pat_i = 0;
  int          wr_idx = 0;
  int          wrreq_seen = 0;
  int          dv_err = 0;
  int          pass_cnt = 0;
  int          chk_cnt = 0;
  bit [6:0]    pat = 7'b1011001;

  // RAM model: sample at the active edge, before DUT state updates.
  always @(posedge clk) begin
    if (ram_rvalid && pend.size() > 0)
      void'(pend.pop_front());
    if (reset_n) begin
      if (ram_rdreq && ram_ready)
        pend.push_back('{ram_addr, cyc + lat});
      if (ram_wrreq) begin
        wrreq_seen++;
        if (mem_datavalid !== ram_ready)
          dv_err++;
        if (ram_ready) begin
          mem[ram_addr] = ram_wdata;
          wr_idx++;
        end
      end else if (mem_datavalid) begin
        rxq.push_back(mem_dataout);
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    case (rdy_mode)
      1:       ram_ready = pat[pat_i % 7];
      2:       ram_ready = pat_i[0];
      default: ram_ready = 1'b1;
    endcase
    pat_i++;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      ram_rvalid = 1'b1;
      ram_rdata  = pend[0].addr;
    end else begin
      ram_rvalid = 1'b0;
      ram_rdata  = '0;
    end
    mem_datain = 32'hD000_0000 + 32'(wr_idx);
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] exp_addr(logic [31:0] start, int i);
    logic [31:0] a;
    logic [2:0]  off;
    off = start[4:2] + 3'(i);
`ifdef MEMCTRL_WRAP_EN
    a = {start[31:5], off, 2'b00};
`else
    a = start + 32'(4 * i);
    off = '0;
`endif
    return a | 32'(off & 3'b000);
  endfunction

  task automatic req(logic [31:0] a, logic rd, logic wr);
    @(negedge clk);
    mem_addr  = a;
    mem_rdreq = rd;
    mem_wrreq = wr;
    @(negedge clk);
    mem_rdreq = 1'b0;
    mem_wrreq = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int k = 0;
    repeat (2) @(negedge clk);
    while (mem_busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_read(string tag, logic [31:0] start);
    wait_idle(300);
    chk({tag, "_beats"}, 32'(rxq.size()), 32'd8);
    for (int i = 0; i < 8 && i < rxq.size(); i++)
      chk($sformatf("%s_d%0d", tag, i), rxq[i], exp_addr(start, i));
    chk({tag, "_busy"}, {31'd0, mem_busy}, 32'd0);
    rxq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    mem_addr  = '0;
    mem_rdreq = 1'b0;
    mem_wrreq = 1'b0;
    #3;
    chk("rst_burstlen", {16'd0, mem_burstlen}, 32'd8);
    chk("rst_outs", {28'd0, mem_datavalid, mem_busy, ram_rdreq, ram_wrreq},
        32'd0);
    chk("rst_dataout", mem_dataout, 32'd0);
    chk("rst_ram_addr", ram_addr, 32'd0);
    chk("rst_ram_wdata", ram_wdata, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    req(32'h0000_0100, 1'b1, 1'b0);
    check_read("rd100", 32'h0000_0100);

    req(32'h0000_0118, 1'b1, 1'b0);
    check_read("rdwrap", 32'h0000_0118);

    rdy_mode = 1;
    pat_i    = 0;
    wr_idx   = 0;
    dv_err   = 0;
    mem.delete();
    req(32'h0000_0203, 1'b0, 1'b1);
    wait_idle(300);
    chk("wr_count", 32'(wr_idx), 32'd8);
    chk("wr_dv_ready", 32'(dv_err), 32'd0);
    chk("wr_entries", 32'(mem.num()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a;
      a = exp_addr(32'h0000_0200, i);
      chk($sformatf("wr_word%0d", i),
          mem.exists(a) ? mem[a] : 32'hxxxx_xxxx,
          32'hD000_0000 + 32'(i));
    end
    chk("wr_rx_none", 32'(rxq.size()), 32'd0);
    rxq.delete();

    rdy_mode   = 0;
    wrreq_seen = 0;
    req(32'h0000_0040, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    mem_addr  = 32'h0000_0500;
    mem_rdreq = 1'b1;
    @(negedge clk);
    mem_rdreq = 1'b0;
    check_read("coll", 32'h0000_0040);
    chk("coll_no_wr", 32'(wrreq_seen), 32'd0);

    lat      = 3;
    rdy_mode = 2;
    req(32'h0000_0180, 1'b1, 1'b0);
    check_read("lat3", 32'h0000_0180);

    lat      = 1;
    rdy_mode = 0;
    req(32'h0000_0280, 1'b1, 1'b0);
    begin
      int k = 0;
      while (rxq.size() < 3 && k < 100) begin
        @(negedge clk);
        k++;
      end
    end
    #2 reset_n = 1'b0;
    #1;
    chk("arst_outs", {28'd0, mem_datavalid, mem_busy, ram_rdreq, ram_wrreq},
        32'd0);
    chk("arst_dataout", mem_dataout, 32'd0);
    chk("arst_ram_addr", ram_addr, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("arst_late_beats", 32'(rxq.size()), 32'd3);
    chk("arst_pend_drained", 32'(pend.size()), 32'd0);
    rxq.delete();

    req(32'h0000_0300, 1'b1, 1'b0);
    check_read("rd300", 32'h0000_0300);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
